// File: rtl/fp32_adder2_synth.sv
// FP32 adder with truncation, denormal flush-to-zero and registered outputs.
// Define FP32_ADDER2_PIPE_EN to add a register stage after alignment, giving a latency of 2.
module fp32_adder2_synth (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] S,
    output logic        Overflow
);
    typedef struct packed {
        logic        special;
        logic [31:0] spec_s;
        logic        both_zero;
        logic        sx;
        logic        sub;
        logic [7:0]  ex;
        logic [23:0] mx;
        logic [23:0] my;
    } stage_t;

    stage_t      st1_d;
    stage_t      st2;
    logic [31:0] s_d, s_q;
    logic        ovf_d, ovf_q;

    // Decode, swap so X holds the larger magnitude, then align Y
    always_comb begin
        logic [7:0]  ea, eb, ey, diff;
        logic        sa, sb, sy, nan_a, nan_b, inf_a, inf_b, swap;
        logic [30:0] key_a, key_b;
        logic [23:0] ma, mb, my;
        ea    = a[30:23];
        eb    = b[30:23];
        sa    = a[31];
        sb    = b[31];
        nan_a = (ea == 8'hFF) && (a[22:0] != 23'd0);
        nan_b = (eb == 8'hFF) && (b[22:0] != 23'd0);
        inf_a = (ea == 8'hFF) && (a[22:0] == 23'd0);
        inf_b = (eb == 8'hFF) && (b[22:0] == 23'd0);
        key_a = (ea == 8'd0) ? 31'd0 : a[30:0];
        key_b = (eb == 8'd0) ? 31'd0 : b[30:0];
        ma    = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
        mb    = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
        swap  = key_b > key_a;

        st1_d          = '0;
        st1_d.special  = (ea == 8'hFF) || (eb == 8'hFF);
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb)))
            st1_d.spec_s = 32'h7FC0_0000;
        else if (ea == 8'hFF)
            st1_d.spec_s = a;
        else
            st1_d.spec_s = b;

        st1_d.sx  = swap ? sb : sa;
        sy        = swap ? sa : sb;
        st1_d.ex  = swap ? eb : ea;
        ey        = swap ? ea : eb;
        st1_d.mx  = swap ? mb : ma;
        my        = swap ? ma : mb;
        st1_d.sub = st1_d.sx ^ sy;
        st1_d.both_zero = (st1_d.ex == 8'd0);
        diff      = st1_d.ex - ey;
        st1_d.my  = (diff >= 8'd24) ? 24'd0 : (my >> diff);
    end

`ifdef FP32_ADDER2_PIPE_EN
    stage_t st1_q;
    always_ff @(posedge clk) begin
        if (rst) st1_q <= '0;
        else     st1_q <= st1_d;
    end
    assign st2 = st1_q;
`else
    assign st2 = st1_d;
`endif

    // Add/subtract, normalize, then classify the exponent
    always_comb begin
        logic [24:0]       sum;
        logic [4:0]        lzc;
        logic              found;
        logic [22:0]       frac;
        logic signed [9:0] exp_n;
        s_d   = 32'd0;
        ovf_d = 1'b0;
        lzc   = 5'd0;
        found = 1'b0;
        frac  = 23'd0;
        exp_n = 10'sd0;
        sum   = st2.sub ? ({1'b0, st2.mx} - {1'b0, st2.my})
                        : ({1'b0, st2.mx} + {1'b0, st2.my});
        for (int i = 23; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lzc   = 5'(23 - i);
                found = 1'b1;
            end
        end

        if (st2.special) begin
            s_d   = st2.spec_s;
            ovf_d = 1'b1;
        end else if (st2.both_zero) begin
            s_d = st2.sub ? 32'h8000_0000 : {st2.sx, 31'd0};
        end else if (st2.sub && (sum == 25'd0)) begin
            s_d = 32'h8000_0000;
        end else begin
            if (!st2.sub && sum[24]) begin
                frac  = sum[23:1];
                exp_n = $signed({2'b00, st2.ex}) + 10'sd1;
            end else if (!st2.sub) begin
                frac  = sum[22:0];
                exp_n = $signed({2'b00, st2.ex});
            end else begin
                // Shifting only the fraction bits drops the leading 1 for free
                frac  = sum[22:0] << lzc;
                exp_n = $signed({2'b00, st2.ex}) - $signed({5'd0, lzc});
            end
            if (exp_n >= 10'sd255) begin
                s_d   = {st2.sx, 8'hFF, 23'd0};
                ovf_d = 1'b1;
            end else if (exp_n <= 10'sd0) begin
                s_d = {st2.sx, 31'd0};
            end else begin
                s_d = {st2.sx, exp_n[7:0], frac};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= 32'd0;
            ovf_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            ovf_q <= ovf_d;
        end
    end

    assign S        = s_q;
    assign Overflow = ovf_q;
endmodule

// File: tb/tb_fp32_adder2_synth.sv
// Directed-vector bench for fp32_adder2_synth; adapts to the configured latency.
module tb_fp32_adder2_synth;
`ifdef FP32_ADDER2_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic [31:0] S;
    logic        Overflow;
    int          checks = 0;
    int          errors = 0;

    fp32_adder2_synth dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .S        (S),
        .Overflow (Overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] es, input logic eo);
        a = va;
        b = vb;
        repeat (LAT) @(posedge clk);
        #1;
        chk({tag, "_S"}, S, es);
        chk({tag, "_ovf"}, {31'd0, Overflow}, {31'd0, eo});
    endtask

    logic [31:0] seq_a [4];
    logic [31:0] seq_b [4];
    logic [31:0] seq_s [4];

    initial begin
        rst = 1'b1;
        a   = 32'd0;
        b   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_S", S, 32'd0);
        chk("reset_ovf", {31'd0, Overflow}, 32'd0);
        rst = 1'b0;

        run("neg45x2",   32'hC234_0000, 32'hC234_0000, 32'hC2B4_0000, 1'b0);
        run("pos45x2",   32'h4234_0000, 32'h4234_0000, 32'h42B4_0000, 1'b0);
        run("x_minus_x", 32'h4000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0);
        run("add_carry", 32'hC01D_0E56, 32'hC000_0000, 32'hC08E_872B, 1'b0);
        run("norm3",     32'hC01D_0E56, 32'h4000_0000, 32'hBEE8_72B0, 1'b0);
        run("trunc_ab",  32'h3FE5_B22D, 32'h42C7_908A, 32'h42CB_2752, 1'b0);
        run("trunc_ba",  32'h42C7_908A, 32'h3FE5_B22D, 32'h42CB_2752, 1'b0);
        run("nan_ab",    32'hFFE8_72B0, 32'h4234_0000, 32'h7FC0_0000, 1'b1);
        run("nan_ba",    32'h4234_0000, 32'hFFE8_72B0, 32'h7FC0_0000, 1'b1);
        run("max_ovf",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1);
        run("inf_minf",  32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b1);
        run("inf_plus1", 32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000, 1'b1);
        run("pz_pz",     32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        run("nz_nz",     32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run("pz_nz",     32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run("denorm",    32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0);
        run("one_dnrm",  32'h3F80_0000, 32'h8000_0001, 32'h3F80_0000, 1'b0);
        run("underflow", 32'h0080_0001, 32'h8080_0000, 32'h0000_0000, 1'b0);
        run("shift24",   32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 1'b0);
        run("shift23",   32'h4B00_0000, 32'h3F80_0000, 32'h4B00_0001, 1'b0);

        // Back-to-back stream: one new pair per cycle, results in order
        seq_a = '{32'h4234_0000, 32'h3F80_0000, 32'hC01D_0E56, 32'h4000_0000};
        seq_b = '{32'h4234_0000, 32'h3F80_0000, 32'h4000_0000, 32'hC000_0000};
        seq_s = '{32'h42B4_0000, 32'h4000_0000, 32'hBEE8_72B0, 32'h8000_0000};
        for (int i = 0; i < 4 + LAT - 1; i++) begin
            if (i < 4) begin
                a = seq_a[i];
                b = seq_b[i];
            end
            @(posedge clk);
            #1;
            if (i + 1 >= LAT) chk($sformatf("stream%0d", i + 1 - LAT), S, seq_s[i + 1 - LAT]);
        end

        // Reset mid-stream wins over capture and clears in-flight results
        a = 32'h7F7F_FFFF;
        b = 32'h7F7F_FFFF;
        @(posedge clk);
        a   = 32'h4234_0000;
        b   = 32'h4234_0000;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_S", S, 32'd0);
        chk("midrst_ovf", {31'd0, Overflow}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        if (LAT == 2) chk("midrst_flush", S, 32'd0);
        run("post_rst",  32'h4234_0000, 32'h4234_0000, 32'h42B4_0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
